// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32I definitions for the instruction encoder:
//               request kind enum, major opcodes, canonical NOP and a
//               signed-range helper.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    typedef enum logic [2:0] {
        KIND_LW    = 3'd0,
        KIND_SW    = 3'd1,
        KIND_RTYPE = 3'd2,
        KIND_BEQ   = 3'd3,
        KIND_ITYPE = 3'd4,
        KIND_JAL   = 3'd5
    } req_kind_e;

    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;

    localparam logic [31:0] c_nop = 32'h00000013;

    // True when value is representable as a signed integer of 'bits' bits:
    // every bit from the would-be sign bit upward must equal bit 31.
    function automatic logic fits_signed(input logic [31:0] value, input int bits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if ((i >= bits - 1) && (value[i] != value[31])) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
// Module      : instr_pack
// Description : Combinational RV32I field packer. Builds the 32-bit word for
//               one request and flags requests that cannot be encoded.
// Ports       : kind/rd/rs1/rs2/funct3/funct7b5/imm in -> word, illegal out
// Revision    : 1.0 - initial release
// ============================================================================
module instr_pack
    import riscv_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    // Shift-immediate forms (SLLI/SRLI/SRAI) carry a 5-bit shamt only.
    logic w_is_shift;
    assign w_is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        word    = c_nop;
        illegal = 1'b0;
        case (kind)
            KIND_LW: begin
                word    = {imm[11:0], rs1, 3'b010, rd, c_opc_load};
                illegal = !fits_signed(imm, 12);
            end
            KIND_SW: begin
                word    = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], c_opc_store};
                illegal = !fits_signed(imm, 12);
            end
            KIND_RTYPE: begin
                word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, c_opc_op};
            end
            KIND_BEQ: begin
                word    = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11],
                           c_opc_branch};
                illegal = !fits_signed(imm, 13) || imm[0];
            end
            KIND_ITYPE: begin
                // Only SRLI/SRAI use inst[30] to tell logical from arithmetic.
                if (funct3 == 3'b101) begin
                    word = {1'b0, funct7b5, 5'b00000, imm[4:0], rs1, funct3, rd,
                            c_opc_op_imm};
                end else begin
                    word = {imm[11:0], rs1, funct3, rd, c_opc_op_imm};
                end
                if (w_is_shift) begin
                    illegal = (imm[31:5] != 27'd0);
                end else begin
                    illegal = !fits_signed(imm, 12);
                end
            end
            KIND_JAL: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, c_opc_jal};
                illegal = !fits_signed(imm, 21) || imm[0];
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Streams encoded RV32I words into instruction memory. Holds
//               the load FSM, the write address (pc), a one-deep output
//               buffer and the word count / sticky error flag.
// Ports       : start/base_addr/finish  - load control
//               req_*, rd..imm          - instruction request handshake
//               wr_*                    - memory write handshake
//               done/err/count          - load status
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        finish,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [31:0] imm,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        done,
    output logic        err,
    output logic [15:0] count
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_wr_valid;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_data;
    logic [15:0] r_count;
    logic        r_err;

    logic [31:0] w_word;
    logic        w_illegal;
    logic        w_accept;
    logic        w_wr_fire;

    instr_pack u_pack (
        .kind     (req_kind),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .imm      (imm),
        .word     (w_word),
        .illegal  (w_illegal)
    );

    // The buffer may be refilled on the same edge it drains.
    assign req_ready = (r_state == c_st_run) && (!r_wr_valid || wr_ready);
    assign w_accept  = req_valid && req_ready;
    assign w_wr_fire = r_wr_valid && wr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_pc       <= 32'd0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 32'd0;
            r_wr_data  <= 32'd0;
            r_count    <= 16'd0;
            r_err      <= 1'b0;
        end else begin
            if (w_wr_fire && (r_count != 16'hFFFF)) begin
                r_count <= r_count + 16'd1;
            end

            // Illegal requests complete the handshake but never reach memory.
            if (w_accept && !w_illegal) begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_pc;
                r_wr_data  <= w_word;
                r_pc       <= r_pc + 32'd4;
            end else if (w_wr_fire) begin
                r_wr_valid <= 1'b0;
            end

            if (w_accept && w_illegal) begin
                r_err <= 1'b1;
            end

            // Placed last so a new load's clears take priority.
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (start) begin
                        r_state <= c_st_run;
                        r_pc    <= base_addr;
                        r_count <= 16'd0;
                        r_err   <= 1'b0;
                    end
                end
                c_st_run: begin
                    if (finish) begin
                        r_state <= c_st_drain;
                    end
                end
                default: begin
                    if (!r_wr_valid || wr_ready) begin
                        r_state <= c_st_done;
                    end
                end
            endcase
        end
    end

    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign count    = r_count;
    assign err      = r_err;
    assign done     = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder: table of encoded
//               requests plus directed multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic        finish = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_kind = 3'd0;
    logic [4:0]  rd = 5'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        funct7b5 = 1'b0;
    logic [31:0] imm = 32'd0;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        done;
    logic        err;
    logic [15:0] count;

    int checks = 0;
    int errors = 0;

    instr_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .finish    (finish),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_kind  (req_kind),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .imm       (imm),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7b5;
        logic [31:0] imm;
        logic        ill;
        logic [31:0] word;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic [2:0] k, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [2:0] f3,
                           input logic f7, input logic [31:0] im);
        req_kind  = k;
        rd        = d;
        rs1       = s1;
        rs2       = s2;
        funct3    = f3;
        funct7b5  = f7;
        imm       = im;
        req_valid = 1'b1;
    endtask

    // Waits (bounded) for req_ready, lets the accept edge happen, drops valid.
    task automatic accept_req(input string name);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s: req_ready timeout got 0 expected 1", name);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] base);
        base_addr = base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [15:0] exp_count;
        logic        exp_err;

        vecs[0]  = '{3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8,         1'b0, 32'h0080006F};
        vecs[1]  = '{3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3,         1'b1, 32'h0};
        vecs[2]  = '{3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0,         1'b0, 32'h402081B3};
        vecs[3]  = '{3'd4, 5'd5, 5'd6, 5'd0, 3'd5, 1'b1, 32'd3,         1'b0, 32'h40335293};
        vecs[4]  = '{3'd4, 5'd1, 5'd1, 5'd0, 3'd1, 1'b0, 32'd32,        1'b1, 32'h0};
        vecs[5]  = '{3'd0, 5'd1, 5'd2, 5'd0, 3'd0, 1'b0, 32'd2048,      1'b1, 32'h0};
        vecs[6]  = '{3'd0, 5'd1, 5'd2, 5'd0, 3'd0, 1'b0, 32'hFFFFF800,  1'b0, 32'h80012083};
        vecs[7]  = '{3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0,         1'b1, 32'h0};
        vecs[8]  = '{3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFFFFE,  1'b0, 32'hFFFFF0EF};
        vecs[9]  = '{3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4096,      1'b1, 32'h0};
        vecs[10] = '{3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFF000,  1'b0, 32'h80000063};
        vecs[11] = '{3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00100000,  1'b1, 32'h0};
        vecs[12] = '{3'd1, 5'd0, 5'd3, 5'd4, 3'd0, 1'b0, 32'hFFFFFFFF,  1'b0, 32'hFE41AFA3};
        vecs[13] = '{3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0,         1'b1, 32'h0};
        vecs[14] = '{3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3,         1'b1, 32'h0};
        vecs[15] = '{3'd4, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 32'd2047,      1'b0, 32'h7FF08093};

        // Reset state
        @(posedge clk); #1;
        chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_count", {16'd0, count}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // First load: single ADDI then finish
        do_start(32'h100);
        chk("run_req_ready", {31'd0, req_ready}, 32'd1);
        set_req(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
        accept_req("addi");
        chk("addi_valid", {31'd0, wr_valid}, 32'd1);
        chk("addi_data", wr_data, 32'h00500093);
        chk("addi_addr", wr_addr, 32'h100);
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        chk("addi_drained", {31'd0, wr_valid}, 32'd0);
        @(posedge clk); #1;
        chk("load1_done", {31'd0, done}, 32'd1);
        chk("load1_count", {16'd0, count}, 32'd1);

        // Restart from DONE: count cleared, LW/SW back-to-back
        do_start(32'h100);
        chk("restart_count", {16'd0, count}, 32'd0);
        chk("restart_done", {31'd0, done}, 32'd0);
        set_req(3'd0, 5'd2, 5'd1, 5'd0, 3'd0, 1'b0, 32'd8);
        @(posedge clk); #1;
        chk("lw_data", wr_data, 32'h0080A103);
        chk("lw_addr", wr_addr, 32'h100);
        set_req(3'd1, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd12);
        chk("b2b_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("sw_valid", {31'd0, wr_valid}, 32'd1);
        chk("sw_data", wr_data, 32'h0020A623);
        chk("sw_addr", wr_addr, 32'h104);
        @(posedge clk); #1;
        chk("b2b_count", {16'd0, count}, 32'd2);

        // BEQ with write back-pressure
        wr_ready = 1'b0;
        set_req(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFFFFFC);
        accept_req("beq");
        chk("beq_addr", wr_addr, 32'h108);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", {31'd0, wr_valid}, 32'd1);
            chk("stall_data", wr_data, 32'hFE208EE3);
            chk("stall_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        wr_ready = 1'b1;
        #1;
        chk("unstall_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        chk("beq_done_valid", {31'd0, wr_valid}, 32'd0);
        chk("beq_count", {16'd0, count}, 32'd3);

        // Encoding table in the same load
        exp_pc    = 32'h10C;
        exp_count = 16'd3;
        exp_err   = 1'b0;
        for (int v = 0; v < 16; v++) begin
            set_req(vecs[v].kind, vecs[v].rd, vecs[v].rs1, vecs[v].rs2,
                    vecs[v].f3, vecs[v].f7b5, vecs[v].imm);
            accept_req("tbl");
            if (vecs[v].ill) exp_err = 1'b1;
            chk($sformatf("tbl%0d_valid", v), {31'd0, wr_valid}, {31'd0, !vecs[v].ill});
            if (!vecs[v].ill) begin
                chk($sformatf("tbl%0d_data", v), wr_data, vecs[v].word);
                chk($sformatf("tbl%0d_addr", v), wr_addr, exp_pc);
                exp_pc    = exp_pc + 32'd4;
                exp_count = exp_count + 16'd1;
            end
            chk($sformatf("tbl%0d_err", v), {31'd0, err}, {31'd0, exp_err});
            @(posedge clk); #1;
        end
        chk("tbl_count", {16'd0, count}, {16'd0, exp_count});

        // finish concurrent with an accept
        set_req(3'd4, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1);
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        req_valid = 1'b0;
        chk("fin_valid", {31'd0, wr_valid}, 32'd1);
        chk("fin_data", wr_data, 32'h00100113);
        chk("fin_addr", wr_addr, exp_pc);
        chk("fin_drain_done", {31'd0, done}, 32'd0);
        chk("fin_drain_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("fin_done", {31'd0, done}, 32'd1);
        chk("fin_count", {16'd0, count}, {16'd0, exp_count + 16'd1});

        // pc wraps modulo 2^32; start clears err
        do_start(32'hFFFFFFFC);
        chk("wrap_err_clr", {31'd0, err}, 32'd0);
        set_req(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
        accept_req("wrap0");
        chk("wrap0_addr", wr_addr, 32'hFFFFFFFC);
        set_req(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
        accept_req("wrap1");
        chk("wrap1_addr", wr_addr, 32'h00000000);
        @(posedge clk); #1;
        chk("wrap_count", {16'd0, count}, 32'd2);

        // Asynchronous reset with a buffered write
        wr_ready = 1'b0;
        set_req(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
        accept_req("pre_rst");
        chk("pre_rst_valid", {31'd0, wr_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, wr_valid}, 32'd0);
        chk("arst_count", {16'd0, count}, 32'd0);
        chk("arst_ready", {31'd0, req_ready}, 32'd0);
        chk("arst_addr", wr_addr, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        wr_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_done", {31'd0, done}, 32'd0);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
